// File: rtl/miner_pkg.sv
// Shared definitions for the multi-core mining controller.
//   PID constants for the USB handshake/data packets sent to the host.
//   hash_state_t: hash dispatch FSM states.
//   tx_state_t:   transmit responder FSM states.
package miner_pkg;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;

  typedef enum logic [2:0] {
    H_IDLE, H_QUIT, H_DISPATCH, H_RUN, H_FOUND, H_EXH
  } hash_state_t;

  typedef enum logic {T_IDLE, T_WAIT} tx_state_t;
endpackage

// File: rtl/multi_core_mining_controller_if.sv
// USB side of the mining controller: host request pulses from the receive
// block and the packet request/payload presented to the transmit block.
//   master: the USB receive/transmit blocks (drive requests, take tx_*).
//   slave:  the controller (takes requests, drives tx_* / pid / payload).
interface multi_core_mining_controller_if #(
  parameter int NONCE_W = 32
);
  logic               host_ready;
  logic               rx_packet_done;
  logic               rx_error;
  logic               host_ack;
  logic               tx_done;
  logic               tx_start;
  logic [7:0]         pid_byte;
  logic [NONCE_W-1:0] data_out;
  logic               tx_has_data;

  modport master (
    output host_ready, rx_packet_done, rx_error, host_ack, tx_done,
    input  tx_start, pid_byte, data_out, tx_has_data
  );

  modport slave (
    input  host_ready, rx_packet_done, rx_error, host_ack, tx_done,
    output tx_start, pid_byte, data_out, tx_has_data
  );
endinterface

// File: rtl/tx_responder.sv
// Transmit responder: answers host OUT packets with ACK/NAK and IN tokens
// with DATA0/DATA1 carrying the found nonce (or zero when nothing is held).
//   clk, n_rst    clock, async active-low reset
//   usb           slave side of the USB interface
//   found         a valid nonce is held
//   found_nonce   the held nonce
//   found_clear   pulse: host acked the DATA packet that carried found_nonce
module tx_responder
  import miner_pkg::*;
#(
  parameter int NONCE_W = 32
) (
  input  logic                          clk,
  input  logic                          n_rst,
  multi_core_mining_controller_if.slave usb,
  input  logic                          found,
  input  logic [NONCE_W-1:0]            found_nonce,
  output logic                          found_clear
);
  tx_state_t state, state_nxt;
  logic hs_pend, data_pend, nak, toggle, data_sent, carried;
  logic hs_req, data_req, svc_hs, svc_data, nak_sel;

  // In T_IDLE a request is serviced in the same cycle it arrives, so the
  // registered tx_start/pid appear one cycle after the request pulse.
  always_comb begin
    state_nxt = state;
    svc_hs    = 1'b0;
    svc_data  = 1'b0;
    hs_req    = hs_pend | usb.rx_packet_done;
    data_req  = data_pend | usb.host_ready;
    nak_sel   = hs_pend ? nak : usb.rx_error;
    case (state)
      T_IDLE: begin
        if (hs_req) begin
          svc_hs    = 1'b1;
          state_nxt = T_WAIT;
        end else if (data_req) begin
          svc_data  = 1'b1;
          state_nxt = T_WAIT;
        end
      end
      T_WAIT:  if (usb.tx_done) state_nxt = T_IDLE;
      default: state_nxt = T_IDLE;
    endcase
  end

  // An ack only counts if a DATA packet went out since the previous ack.
  assign found_clear = usb.host_ack & data_sent & carried;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state           <= T_IDLE;
      hs_pend         <= 1'b0;
      data_pend       <= 1'b0;
      nak             <= 1'b0;
      toggle          <= 1'b0;
      data_sent       <= 1'b0;
      carried         <= 1'b0;
      usb.tx_start    <= 1'b0;
      usb.pid_byte    <= '0;
      usb.data_out    <= '0;
      usb.tx_has_data <= 1'b0;
    end else begin
      state        <= state_nxt;
      usb.tx_start <= svc_hs | svc_data;
      if (svc_hs) begin
        usb.pid_byte    <= nak_sel ? PID_NAK : PID_ACK;
        usb.tx_has_data <= 1'b0;
        usb.data_out    <= '0;
      end else if (svc_data) begin
        usb.pid_byte    <= toggle ? PID_DATA1 : PID_DATA0;
        usb.tx_has_data <= 1'b1;
        usb.data_out    <= found ? found_nonce : '0;
      end else if (state == T_WAIT && usb.tx_done) begin
        usb.pid_byte    <= '0;
        usb.tx_has_data <= 1'b0;
        usb.data_out    <= '0;
      end
      // Pending flags only accumulate while busy; in idle everything
      // outstanding is either serviced now or, for data behind a
      // handshake, carried over.
      hs_pend   <= (state == T_WAIT) & hs_req;
      data_pend <= (state == T_WAIT) ? data_req : (svc_hs & data_req);
      if (state == T_WAIT && usb.rx_packet_done && !hs_pend)
        nak <= usb.rx_error;
      if (usb.host_ack && data_sent) toggle <= ~toggle;
      if (svc_data) begin
        data_sent <= 1'b1;
        carried   <= found;
      end else if (usb.host_ack) begin
        data_sent <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/multi_core_mining_controller.sv
// Multi-core mining controller: dispatches a block across NUM_CORES hash
// cores with interleaved nonces (core i searches i, i+N, i+2N, ...),
// captures the first valid nonce and reports it to the host over USB.
//   clk, n_rst   clock, async active-low reset
//   new_block    pulse: new header loaded, restart the search
//   core_done    per-core hash finished; core_valid qualifies it
//   begin_hash   per-core start pulse; quit_hash aborts all cores
//   core_nonce   per-core nonce, core i at [i*NONCE_W +: NONCE_W]
//   usb          slave side of the USB interface
//   found        valid nonce held; exhausted: search ended without a hit
module multi_core_mining_controller
  import miner_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = 32
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           new_block,
  input  logic [NUM_CORES-1:0]           core_done,
  input  logic [NUM_CORES-1:0]           core_valid,
  output logic [NUM_CORES-1:0]           begin_hash,
  output logic                           quit_hash,
  output logic [NUM_CORES*NONCE_W-1:0]   core_nonce,
  multi_core_mining_controller_if.slave  usb,
  output logic                           found,
  output logic                           exhausted
);
  localparam logic [NONCE_W:0] STEP = (NONCE_W+1)'(NUM_CORES);

  hash_state_t hstate, hstate_nxt;
  logic [NUM_CORES-1:0][NONCE_W-1:0] nonce_q;
  logic [NUM_CORES-1:0][NONCE_W:0]   sum;
  logic [NUM_CORES-1:0]              carry, retired, bh_pend, done_inv;
  logic [NONCE_W-1:0]                found_nonce, hit_nonce;
  logic                              hit, run_act, all_ret, found_clear;

  // The packed 2-D array has exactly the flat per-core layout.
  assign core_nonce = nonce_q;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    // One extra bit so overflow past the nonce space shows up as carry.
    assign sum[i]   = {1'b0, nonce_q[i]} + STEP;
    assign carry[i] = sum[i][NONCE_W];
  end

  assign done_inv   = core_done & ~core_valid & ~retired;
  assign run_act    = (hstate == H_RUN) & ~new_block;
  assign all_ret    = &(retired | (done_inv & carry));
  assign begin_hash = bh_pend | {NUM_CORES{hstate == H_DISPATCH}};

  always_comb begin
    hit        = 1'b0;
    hit_nonce  = '0;
    hstate_nxt = hstate;
    // Descending scan so the lowest-index valid core wins.
    for (int i = NUM_CORES-1; i >= 0; i--) begin
      if (core_done[i] && core_valid[i]) begin
        hit       = 1'b1;
        hit_nonce = nonce_q[i];
      end
    end
    if (new_block) begin
      hstate_nxt = (hstate == H_RUN) ? H_QUIT : H_DISPATCH;
    end else begin
      case (hstate)
        H_QUIT:     hstate_nxt = H_DISPATCH;
        H_DISPATCH: hstate_nxt = H_RUN;
        H_RUN: begin
          if (hit)          hstate_nxt = H_FOUND;
          else if (all_ret) hstate_nxt = H_EXH;
        end
        default:    hstate_nxt = hstate;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hstate      <= H_IDLE;
      nonce_q     <= '0;
      retired     <= '0;
      bh_pend     <= '0;
      quit_hash   <= 1'b0;
      found       <= 1'b0;
      found_nonce <= '0;
      exhausted   <= 1'b0;
    end else begin
      hstate    <= hstate_nxt;
      quit_hash <= (hstate_nxt == H_QUIT) | (run_act & hit);
      bh_pend   <= (run_act & ~hit) ? (done_inv & ~carry) : '0;
      if (new_block)
        retired <= '0;
      else if (run_act && !hit)
        retired <= retired | (done_inv & carry);

      if (hstate_nxt == H_DISPATCH) begin
        for (int i = 0; i < NUM_CORES; i++) nonce_q[i] <= NONCE_W'(i);
      end else if (run_act && !hit) begin
        for (int i = 0; i < NUM_CORES; i++)
          if (done_inv[i] && !carry[i]) nonce_q[i] <= sum[i][NONCE_W-1:0];
      end

      if (new_block) begin
        found     <= 1'b0;
        exhausted <= 1'b0;
      end else if (run_act && hit) begin
        found       <= 1'b1;
        found_nonce <= hit_nonce;
      end else begin
        if (found_clear)            found     <= 1'b0;
        if (run_act && all_ret)     exhausted <= 1'b1;
      end
    end
  end

  tx_responder #(.NONCE_W(NONCE_W)) u_tx (
    .clk         (clk),
    .n_rst       (n_rst),
    .usb         (usb),
    .found       (found),
    .found_nonce (found_nonce),
    .found_clear (found_clear)
  );
endmodule

// File: tb/tb_multi_core_mining_controller.sv
module tb_multi_core_mining_controller;
  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         new_block = 1'b0;
  logic [3:0]   core_done = '0, core_valid = '0;
  logic [3:0]   begin_hash;
  logic         quit_hash, found, exhausted;
  logic [127:0] core_nonce;

  logic         nb2 = 1'b0;
  logic [3:0]   done2 = '0, valid2 = '0;
  logic [3:0]   begin_hash2;
  logic         quit2, found2, exh2;
  logic [15:0]  core_nonce2;

  int errs = 0;
  int checks = 0;

  multi_core_mining_controller_if #(.NONCE_W(32)) bus ();
  multi_core_mining_controller_if #(.NONCE_W(4))  bus2 ();

  multi_core_mining_controller #(.NUM_CORES(4), .NONCE_W(32)) dut (
    .clk(clk), .n_rst(n_rst), .new_block(new_block),
    .core_done(core_done), .core_valid(core_valid),
    .begin_hash(begin_hash), .quit_hash(quit_hash), .core_nonce(core_nonce),
    .usb(bus), .found(found), .exhausted(exhausted)
  );

  multi_core_mining_controller #(.NUM_CORES(4), .NONCE_W(4)) dut2 (
    .clk(clk), .n_rst(n_rst), .new_block(nb2),
    .core_done(done2), .core_valid(valid2),
    .begin_hash(begin_hash2), .quit_hash(quit2), .core_nonce(core_nonce2),
    .usb(bus2), .found(found2), .exhausted(exh2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.host_ready = 0; bus.rx_packet_done = 0; bus.rx_error = 0;
    bus.host_ack = 0;   bus.tx_done = 0;
    bus2.host_ready = 0; bus2.rx_packet_done = 0; bus2.rx_error = 0;
    bus2.host_ack = 0;   bus2.tx_done = 0;
    tick(); tick();
    chk("rst_begin", 64'(begin_hash), 0);
    chk("rst_quit", 64'(quit_hash), 0);
    chk("rst_nonce", 64'(core_nonce[63:0]), 0);
    chk("rst_pid", 64'(bus.pid_byte), 0);
    chk("rst_txs", 64'(bus.tx_start), 0);
    chk("rst_flags", 64'({found, exhausted}), 0);
    n_rst = 1'b1;
    tick();

    // Exhaustion on a 4-bit nonce space: 4 dispatches per core.
    nb2 = 1; tick(); nb2 = 0;
    chk("x_begin", 64'(begin_hash2), 64'hF);
    chk("x_nonce0", 64'(core_nonce2), 64'h3210);
    tick();
    for (int k = 0; k < 3; k++) begin
      done2 = 4'hF; tick(); done2 = 0;
      chk("x_rebegin", 64'(begin_hash2), 64'hF);
      tick();
    end
    chk("x_nonce3", 64'(core_nonce2), 64'hFEDC);
    chk("x_notexh", 64'(exh2), 0);
    done2 = 4'hF; tick(); done2 = 0;
    chk("x_exh", 64'(exh2), 1);
    chk("x_noretry", 64'(begin_hash2), 0);
    chk("x_hold", 64'(core_nonce2), 64'hFEDC);
    bus2.host_ready = 1; tick(); bus2.host_ready = 0;
    chk("x_pid", 64'(bus2.pid_byte), 64'hC3);
    chk("x_empty", 64'({bus2.tx_has_data, bus2.data_out}), 64'h10);
    bus2.tx_done = 1; tick(); bus2.tx_done = 0;

    // Dispatch from idle, one invalid completion, then a double valid hit.
    new_block = 1; tick(); new_block = 0;
    chk("d_begin", 64'(begin_hash), 64'hF);
    chk("d_nonce", core_nonce[127:64] << 0, 64'h00000003_00000002);
    chk("d_nonce_lo", core_nonce[63:0], 64'h00000001_00000000);
    tick();
    chk("d_begin_off", 64'(begin_hash), 0);
    core_done = 4'b0010; tick(); core_done = 0;
    chk("i_nonce1", 64'(core_nonce[63:32]), 5);
    chk("i_begin", 64'(begin_hash), 64'h2);
    tick();
    core_done = 4'b0110; core_valid = 4'b0110; tick();
    core_done = 0; core_valid = 0;
    chk("v_found", 64'(found), 1);
    chk("v_quit", 64'(quit_hash), 1);
    tick();
    chk("v_quit_off", 64'(quit_hash), 0);
    core_done = 4'hF; tick(); core_done = 0;
    chk("v_ignore_done", 64'({begin_hash, core_nonce[31:0]}), 0);

    bus.host_ready = 1; tick(); bus.host_ready = 0;
    chk("t_start", 64'(bus.tx_start), 1);
    chk("t_pid0", 64'(bus.pid_byte), 64'hC3);
    chk("t_data5", 64'({bus.tx_has_data, bus.data_out}), 64'h1_00000005);
    tick();
    chk("t_start_off", 64'(bus.tx_start), 0);
    chk("t_pid_hold", 64'(bus.pid_byte), 64'hC3);
    bus.tx_done = 1; tick(); bus.tx_done = 0;
    chk("t_pid_clr", 64'(bus.pid_byte), 0);
    bus.host_ack = 1; tick(); bus.host_ack = 0;
    chk("a_found_clr", 64'(found), 0);
    bus.host_ready = 1; tick(); bus.host_ready = 0;
    chk("a_pid1", 64'(bus.pid_byte), 64'h4B);
    chk("a_empty", 64'(bus.data_out), 0);
    bus.tx_done = 1; tick(); bus.tx_done = 0;

    // NAK and DATA requested in the same cycle: NAK first.
    bus.rx_packet_done = 1; bus.rx_error = 1; bus.host_ready = 1; tick();
    bus.rx_packet_done = 0; bus.rx_error = 0; bus.host_ready = 0;
    chk("n_pid", 64'(bus.pid_byte), 64'h5A);
    chk("n_nodata", 64'(bus.tx_has_data), 0);
    tick();
    bus.tx_done = 1; tick(); bus.tx_done = 0;
    chk("n_idle_gap", 64'({bus.tx_start, bus.pid_byte}), 0);
    tick();
    chk("n_data_start", 64'(bus.tx_start), 1);
    chk("n_data_pid", 64'(bus.pid_byte), 64'h4B);
    tick();
    // tx_done and a new OUT packet in the same cycle.
    bus.tx_done = 1; bus.rx_packet_done = 1; tick();
    bus.tx_done = 0; bus.rx_packet_done = 0;
    chk("q_gap", 64'(bus.tx_start), 0);
    tick();
    chk("q_ack", 64'({bus.tx_start, bus.pid_byte}), 64'h1D2);
    bus.tx_done = 1; tick(); bus.tx_done = 0;
    // Second ack without a DATA packet in between must not flip the toggle.
    bus.host_ack = 1; tick(); bus.host_ack = 0;
    bus.host_ack = 1; tick(); bus.host_ack = 0;
    bus.host_ready = 1; tick(); bus.host_ready = 0;
    chk("k_toggle", 64'(bus.pid_byte), 64'hC3);
    bus.tx_done = 1; tick(); bus.tx_done = 0;

    // new_block while running: quit then redispatch.
    new_block = 1; tick(); new_block = 0;
    tick();
    core_done = 4'b0001; tick(); core_done = 0;
    chk("r_nonce0", 64'(core_nonce[31:0]), 4);
    new_block = 1; tick(); new_block = 0;
    chk("r_quit", 64'(quit_hash), 1);
    chk("r_nobegin", 64'(begin_hash), 0);
    tick();
    chk("r_begin", 64'(begin_hash), 64'hF);
    chk("r_nonce_rst", 64'(core_nonce[31:0]), 0);
    chk("r_quit_off", 64'(quit_hash), 0);
    tick();

    // Asynchronous reset in the middle of a DATA transmission.
    bus.host_ready = 1; tick(); bus.host_ready = 0;
    tick();
    chk("w_pid", 64'(bus.pid_byte), 64'hC3);
    #2 n_rst = 1'b0;
    #1;
    chk("w_rst_tx", 64'({bus.tx_start, bus.tx_has_data, bus.pid_byte}), 0);
    chk("w_rst_nonce", core_nonce[127:64], 0);
    chk("w_rst_nonce_lo", core_nonce[63:0], 0);
    tick();
    n_rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
